// File: rtl/float8_to_int.sv
// float8_to_int: e4m3 -> rounded, saturated, +7-biased 4-bit code, 2-stage valid/ready; stats under FLOAT8_TO_INT_STATS_EN
module float8_to_int #(
    parameter int float8_type = 0,
    parameter int output_bias = 7,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       float_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       int_val,
    output logic             out_sat,
    output logic             out_nan,
    input  logic             clr_counts,
    output logic [CNT_W-1:0] sat_count,
    output logic [CNT_W-1:0] nan_count
);
    if (float8_type != 0 || output_bias != 7) begin : g_bad_cfg
        $error("float8_to_int supports only e4m3 input with output_bias 7");
    end
    logic       s1_valid, s1_sign, s1_nan, s2_ready;
    logic [3:0] s1_mag, mag, code;
    logic [3:0] e;
    logic [2:0] m;
    logic       sat;
    assign e        = float_val[6:3];
    assign m        = float_val[2:0];
    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;
    // rounded magnitude, ties away from zero, clamped at 9 (anything above 8 saturates either sign)
    always_comb begin
        mag = e <= 4'd5 ? 4'd0 :
              e == 4'd6 ? 4'd1 :
              e == 4'd7 ? (m[2] ? 4'd2 : 4'd1) :
              e == 4'd8 ? (m < 3'd2 ? 4'd2 : m < 3'd6 ? 4'd3 : 4'd4) :
              e == 4'd9 ? 4'd4 + (({1'b0, m} + 4'd1) >> 1) :
              e == 4'd10 ? (m == 3'd0 ? 4'd8 : 4'd9) : 4'd9;
        sat  = !s1_nan && (s1_sign ? s1_mag > 4'd7 : s1_mag > 4'd8);
        code = s1_nan ? 4'd7 :
               s1_sign ? (sat ? 4'd0 : 4'd7 - s1_mag) :
               (sat ? 4'd15 : s1_mag + 4'd7);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= 4'd0;
            s1_nan   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= float_val[7];
                s1_mag  <= mag;
                s1_nan  <= &float_val[6:0];
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            int_val   <= 4'd0;
            out_sat   <= 1'b0;
            out_nan   <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                int_val <= code;
                out_sat <= sat;
                out_nan <= s1_nan;
            end
        end
    end
`ifdef FLOAT8_TO_INT_STATS_EN
    logic hs;
    assign hs = out_valid && out_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
            nan_count <= '0;
        end else if (clr_counts) begin
            sat_count <= '0;
            nan_count <= '0;
        end else begin
            if (hs && out_sat && !(&sat_count)) sat_count <= sat_count + 1'b1;
            if (hs && out_nan && !(&nan_count)) nan_count <= nan_count + 1'b1;
        end
    end
`else
    logic unused_clr;
    assign unused_clr = clr_counts;
    assign sat_count  = '0;
    assign nan_count  = '0;
`endif
endmodule
